// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width for N requesters; never narrower than one bit.
    function automatic int unsigned calc_idx_w(input int unsigned n);
        if (n <= 32'd1) return 32'd1;
        return 32'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority encoder: first request above ptr, wrapping.
module rr_select
    import stream_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = calc_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Scan ptr+1 .. ptr+N modulo N and keep the first hit.
    always_comb begin
        int unsigned idx;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!grant_any && req[IDX_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin valid/ready arbiter feeding a two-entry (main + skid) output stage.
// Define STREAM_RR_ARBITER_LOCK_EN to hold the grant for a whole packet (in_last).
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int unsigned N_INPUTS   = 4,
    parameter  int unsigned WORD_WIDTH = 32,
    localparam int unsigned IDX_W      = calc_idx_w(N_INPUTS)
) (
    input  logic                                clock,
    input  logic                                rst_n,
    input  logic [N_INPUTS-1:0]                 in_valid,
    output logic [N_INPUTS-1:0]                 in_ready,
    input  logic [N_INPUTS-1:0][WORD_WIDTH-1:0] in_data,
`ifdef STREAM_RR_ARBITER_LOCK_EN
    input  logic [N_INPUTS-1:0]                 in_last,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WORD_WIDTH-1:0]               out_data,
    output logic [IDX_W-1:0]                    out_src,
    output logic                                out_last
);

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any;
    logic [IDX_W-1:0]      grant;
    logic                  grant_any;
    logic                  can_accept;
    logic                  xfer;

    logic                  main_valid_q, main_valid_d;
    logic [WORD_WIDTH-1:0] main_data_q,  main_data_d;
    logic [IDX_W-1:0]      main_src_q,   main_src_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [WORD_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [IDX_W-1:0]      skid_src_q,   skid_src_d;

    rr_select #(.N(N_INPUTS)) u_rr_select (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant_idx (sel_idx),
        .grant_any (sel_any)
    );

`ifdef STREAM_RR_ARBITER_LOCK_EN
    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             beat_last;
    logic             main_last_q, main_last_d;
    logic             skid_last_q, skid_last_d;

    // While a packet is open the grant is pinned to its owner.
    always_comb begin
        grant     = sel_idx;
        grant_any = sel_any;
        if (state_q == LOCKED) begin
            grant     = lock_idx_q;
            grant_any = 1'b1;
        end
    end

    assign beat_last = in_last[grant];

    // Packet lock FSM: open on a non-last beat, close on the owner's last beat.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            IDLE: begin
                if (xfer && !beat_last) begin
                    state_d    = LOCKED;
                    lock_idx_d = grant;
                end
            end
            LOCKED: begin
                if (xfer && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Last flag travels alongside the main/skid payloads.
    always_comb begin
        main_last_d = main_last_q;
        skid_last_d = skid_last_q;
        if (skid_valid_q) begin
            if (out_ready) main_last_d = skid_last_q;
        end else if (xfer) begin
            if (!main_valid_q || out_ready) main_last_d = beat_last;
            else                            skid_last_d = beat_last;
        end
    end

    // Last flag registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            main_last_q <= 1'b0;
            skid_last_q <= 1'b0;
        end else begin
            main_last_q <= main_last_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign out_last = main_last_q;
`else
    assign grant     = sel_idx;
    assign grant_any = sel_any;
    assign out_last  = 1'b1;
`endif

    // Accept only while the skid slot is free, so in_ready never sees out_ready.
    assign can_accept = !skid_valid_q;
    assign xfer       = can_accept && grant_any && in_valid[grant];

    // One-hot ready toward the granted requester.
    always_comb begin
        in_ready = '0;
        if (can_accept && grant_any) in_ready[grant] = 1'b1;
    end

    // Pointer update and main/skid routing.
    always_comb begin
        ptr_d        = ptr_q;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_src_d   = main_src_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_src_d   = skid_src_q;
        if (xfer) ptr_d = grant;
        if (skid_valid_q) begin
            if (out_ready) begin
                main_data_d  = skid_data_q;
                main_src_d   = skid_src_q;
                skid_valid_d = 1'b0;
            end
        end else if (xfer) begin
            if (!main_valid_q || out_ready) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data[grant];
                main_src_d   = grant;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data[grant];
                skid_src_d   = grant;
            end
        end else if (out_ready) begin
            main_valid_d = 1'b0;
        end
    end

    // Pointer and output stage registers; requester 0 wins first after reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= IDX_W'(N_INPUTS - 1);
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_src_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_src_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_src_q   <= main_src_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_src_q   <= skid_src_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_src   = main_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed steps plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;
    localparam int unsigned NI = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] src;
        logic          last;
    } beat_t;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    logic [NI-1:0]        in_valid, in_ready;
    logic [NI-1:0][W-1:0] in_data;
`ifdef STREAM_RR_ARBITER_LOCK_EN
    logic [NI-1:0]        in_last;
    logic [0:0]           l1;
`endif
    logic                 out_valid, out_ready, out_last;
    logic [W-1:0]         out_data;
    logic [IW-1:0]        out_src;

    logic [0:0]           v1, r1;
    logic [0:0][W-1:0]    d1;
    logic                 ov1, or1, ol1;
    logic [W-1:0]         od1;
    logic [0:0]           os1;

    stream_rr_arbiter #(.N_INPUTS(NI), .WORD_WIDTH(W)) dut (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef STREAM_RR_ARBITER_LOCK_EN
        .in_last(in_last),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_last(out_last)
    );

    stream_rr_arbiter #(.N_INPUTS(1), .WORD_WIDTH(W)) dut1 (
        .clock(clock), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1), .in_data(d1),
`ifdef STREAM_RR_ARBITER_LOCK_EN
        .in_last(l1),
`endif
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .out_src(os1), .out_last(ol1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    beat_t          mq[$];
    int             last_g, lock_src;
    bit             locked;
    bit             req_v[NI];
    logic [W-1:0]   req_d[NI];
    bit             req_l[NI];
    int             budget[NI], pkt_len[NI], beat_no[NI], seq[NI];
    bit             rnd_mode;
    int             acc_count = 0;
    int             pop_src[$];
    logic [W-1:0]   pop_data[$];
    logic [NI-1:0]  rdy_hist[$];
    bit             ov_hist[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Spec-level grant: owner of an open packet, else first valid after the last winner.
    function automatic int model_grant();
        if (locked) return lock_src;
        for (int k = 1; k <= NI; k++) begin
            int i = (last_g + k) % NI;
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NI; i++)
            if (req_v[i] || budget[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        mq.delete();
        last_g = NI - 1;
        locked = 1'b0;
        lock_src = 0;
        for (int i = 0; i < NI; i++) begin
            req_v[i] = 1'b0; req_d[i] = '0; req_l[i] = 1'b0;
            budget[i] = 0; pkt_len[i] = 1; beat_no[i] = 0;
        end
    endtask

    task automatic clear_hist();
        pop_src.delete(); pop_data.delete(); rdy_hist.delete(); ov_hist.delete();
    endtask

    task automatic arm_all();
        for (int i = 0; i < NI; i++) begin
            if (!req_v[i] && budget[i] > 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                req_v[i] = 1'b1;
                req_d[i] = {8'(i), 24'(seq[i])};
                seq[i]++;
                req_l[i] = rnd_mode ? (budget[i] == 1 || $urandom_range(0, 2) == 0)
                                    : (beat_no[i] == pkt_len[i] - 1);
            end
        end
    endtask

    task automatic tick();
        int g;
        logic [NI-1:0] exp_rdy;
        bit xfer, pop;
        beat_t b;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = req_v[i];
            in_data[i]  = req_d[i];
`ifdef STREAM_RR_ARBITER_LOCK_EN
            in_last[i]  = req_l[i];
`endif
        end
        @(negedge clock);
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0 && mq.size() < 2) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(mq[0].data));
            chk("out_src", 64'(out_src), 64'(mq[0].src));
            chk("out_last", 64'(out_last), 64'(mq[0].last));
        end
        rdy_hist.push_back(in_ready);
        ov_hist.push_back(out_valid);
        xfer = 1'b0;
        b = '0;
        if (g >= 0) begin
            if (exp_rdy[g] && in_valid[g]) begin
                xfer = 1'b1;
                b.data = in_data[g];
                b.src = IW'(g);
`ifdef STREAM_RR_ARBITER_LOCK_EN
                b.last = in_last[g];
`else
                b.last = 1'b1;
`endif
            end
        end
        pop = (mq.size() > 0) && out_ready;
        if (pop) begin
            pop_src.push_back(int'(mq[0].src));
            pop_data.push_back(mq[0].data);
        end
        @(posedge clock);
        #1;
        if (pop) void'(mq.pop_front());
        if (xfer) begin
            mq.push_back(b);
            last_g = g;
            acc_count++;
            if (!locked && !b.last) begin
                locked = 1'b1;
                lock_src = g;
            end else if (locked && b.last) begin
                locked = 1'b0;
            end
            budget[g]--;
            beat_no[g] = b.last ? 0 : beat_no[g] + 1;
            req_v[g] = 1'b0;
        end
        arm_all();
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run_out(input int limit);
        int n = 0;
        while (n < limit && (mq.size() > 0 || any_pending())) begin
            tick();
            n++;
        end
        chk("run_out_in_time", 64'(n < limit), 64'd1);
    endtask

    int t1_exp[5] = '{0, 1, 2, 3, 0};
    int t4_exp[5] = '{0, 1, 1, 1, 0};

    initial begin
        int a;
        int n;
        logic [NI-1:0] acc_m;
        logic [W-1:0] q1[$];
        logic [W-1:0] outs1[$];
        int sent;
        bit acc1, pop1;

        rst_n = 1'b0;
        out_ready = 1'b0;
        in_valid = '0;
        in_data = '0;
`ifdef STREAM_RR_ARBITER_LOCK_EN
        in_last = '0;
        l1 = 1'b1;
`endif
        v1 = '0; d1 = '0; or1 = 1'b0;
        rnd_mode = 1'b0;
        for (int i = 0; i < NI; i++) seq[i] = 0;
        reset_model();

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_src", 64'(out_src), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
`ifdef STREAM_RR_ARBITER_LOCK_EN
        chk("reset_out_last", 64'(out_last), 64'd0);
`else
        chk("reset_out_last", 64'(out_last), 64'd1);
`endif
        chk("reset_n1_out_valid", 64'(ov1), 64'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // All four requesting: strict rotation starting at 0.
        clear_hist();
        out_ready = 1'b1;
        for (int i = 0; i < NI; i++) budget[i] = 2;
        arm_all();
        run_out(40);
        chk("t1_first_ready", 64'(rdy_hist[0]), 64'h1);
        chk("t1_first_valid", 64'(ov_hist[0]), 64'd0);
        for (int k = 1; k <= 8; k++) chk("t1_back_to_back", 64'(ov_hist[k]), 64'd1);
        for (int k = 0; k < 5; k++) chk("t1_src_seq", 64'(pop_src[k]), 64'(t1_exp[k]));

        // Requesters 1 and 3 only: alternate, never ready toward 0 or 2.
        clear_hist();
        budget[1] = 4;
        budget[3] = 4;
        arm_all();
        run_out(40);
        acc_m = '0;
        foreach (rdy_hist[k]) acc_m |= rdy_hist[k];
        chk("t2_no_ready_0_2", 64'(acc_m & 4'b0101), 64'd0);
        chk("t2_count", 64'(pop_src.size()), 64'd8);
        for (int k = 0; k < 8; k++) chk("t2_alternate", 64'(pop_src[k]), (k % 2 == 0) ? 64'd1 : 64'd3);

        // Backpressure on a single stream: one skid beat, then ready low.
        clear_hist();
        budget[2] = 8;
        arm_all();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        a = acc_count;
        repeat (3) tick();
        chk("t3_one_skid_beat", 64'(acc_count - a), 64'd1);
        chk("t3_ready_low_a", 64'(rdy_hist[3]), 64'd0);
        chk("t3_ready_low_b", 64'(rdy_hist[4]), 64'd0);
        out_ready = 1'b1;
        run_out(40);
        chk("t3_count", 64'(pop_data.size()), 64'd8);
        for (int k = 1; k < 8; k++) chk("t3_order", 64'(pop_data[k]), 64'(pop_data[0] + W'(k)));

`ifdef STREAM_RR_ARBITER_LOCK_EN
        // Packet lock: source 1's 3-beat packet is not interleaved with source 0.
        clear_hist();
        budget[0] = 1;
        arm_all();
        run_out(20);
        pkt_len[1] = 3;
        budget[1] = 3;
        budget[0] = 1;
        arm_all();
        run_out(40);
        chk("t4_count", 64'(pop_src.size()), 64'd5);
        for (int k = 0; k < 5; k++) chk("t4_src_seq", 64'(pop_src[k]), 64'(t4_exp[k]));
`endif

        // Random traffic against the model.
        clear_hist();
        rnd_mode = 1'b1;
        for (int i = 0; i < NI; i++) budget[i] = 40;
        arm_all();
        n = 0;
        while (n < 3000 && any_pending()) begin
            tick();
            n++;
        end
        chk("rnd_in_time", 64'(n < 3000), 64'd1);
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        run_out(50);
        chk("rnd_count", 64'(pop_src.size()), 64'd160);

        // Reset mid-stall / mid-packet drops everything.
        clear_hist();
        out_ready = 1'b0;
        pkt_len[2] = 4;
        budget[2] = 4;
        arm_all();
        a = acc_count;
        n = 0;
        while (n < 10 && acc_count - a < 2) begin
            tick();
            n++;
        end
        chk("t5_two_accepted", 64'(acc_count - a), 64'd2);
        chk("t5_valid_before_reset", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_async_clear", 64'(out_valid), 64'd0);
        chk("t5_data_async_clear", 64'(out_data), 64'd0);
        chk("t5_src_async_clear", 64'(out_src), 64'd0);
        reset_model();
        in_valid = '0;
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        clear_hist();
        out_ready = 1'b1;
        budget[0] = 1;
        budget[3] = 1;
        arm_all();
        run_out(20);
        chk("t5_first_grant_ready", 64'(rdy_hist[0]), 64'h1);
        chk("t5_first_grant_src", 64'(pop_src[0]), 64'd0);

        // Single-requester instance: pass-through with skid, random out_ready.
        sent = 0;
        n = 0;
        while (n < 200 && outs1.size() < 8) begin
            v1 = (sent < 8);
            d1[0] = W'(32'h10 + sent);
            or1 = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("n1_in_ready", 64'(r1), 64'(v1[0] && q1.size() < 2));
            chk("n1_out_valid", 64'(ov1), 64'(q1.size() > 0));
            if (q1.size() > 0) begin
                chk("n1_out_data", 64'(od1), 64'(q1[0]));
                chk("n1_out_src", 64'(os1), 64'd0);
                chk("n1_out_last", 64'(ol1), 64'd1);
            end
            acc1 = v1[0] && q1.size() < 2;
            pop1 = q1.size() > 0 && or1;
            if (pop1) outs1.push_back(q1[0]);
            @(posedge clock);
            #1;
            if (pop1) void'(q1.pop_front());
            if (acc1) begin
                q1.push_back(d1[0]);
                sent++;
            end
            n++;
        end
        chk("n1_count", 64'(outs1.size()), 64'd8);
        foreach (outs1[k]) chk("n1_sequence", 64'(outs1[k]), 64'(32'h10 + k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
